// File: rtl/riscv_core_mulctl_pkg.sv
// Shared types for the multiply sequencer: FSM states, registered request
// record and the counter-width helper.
package riscv_core_mulctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } mulctl_state_t;

    // The request record is sized for the widest supported operands and tags;
    // narrower instances use the low bits only.
    localparam int MULCTL_XLEN  = 64;
    localparam int MULCTL_TAG_W = 5;

    typedef struct packed {
        logic [MULCTL_XLEN-1:0]  srcA;
        logic [MULCTL_XLEN-1:0]  srcB;
        logic [1:0]              control;
        logic                    isword;
        logic [MULCTL_TAG_W-1:0] rd;
    } mulctl_req_t;

    function automatic int mulctl_cnt_w(input int mul_cycles);
        return $clog2(mul_cycles + 1);
    endfunction

endpackage

// File: rtl/riscv_core_mul_ctrl.sv
// Sequencer around the combinational multiplier: holds operands stable for
// MUL_CYCLES cycles, captures the product and hands it to writeback.
module riscv_core_mul_ctrl
    import riscv_core_mulctl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             i_mulctl_clk,
    input  logic             i_mulctl_rst,
    input  logic             i_mulctl_valid,
    output logic             o_mulctl_ready,
    input  logic [XLEN-1:0]  i_mulctl_srcA,
    input  logic [XLEN-1:0]  i_mulctl_srcB,
    input  logic [1:0]       i_mulctl_control,
    input  logic             i_mulctl_isword,
    input  logic [TAG_W-1:0] i_mulctl_rd,
    input  logic             i_mulctl_flush,
    output logic [XLEN-1:0]  o_mulctl_mul_srcA,
    output logic [XLEN-1:0]  o_mulctl_mul_srcB,
    output logic [1:0]       o_mulctl_mul_control,
    output logic             o_mulctl_mul_isword,
    output logic             o_mulctl_mul_en,
    input  logic [XLEN-1:0]  i_mulctl_mul_result,
    output logic             o_mulctl_valid,
    input  logic             i_mulctl_out_ready,
    output logic [XLEN-1:0]  o_mulctl_result,
    output logic [TAG_W-1:0] o_mulctl_rd,
    output logic             o_mulctl_busy
);

    localparam int CNT_W = mulctl_cnt_w(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    mulctl_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    mulctl_req_t      req_q;
    mulctl_req_t      req_d;
    logic [XLEN-1:0]  result_q;
    logic             valid_q;
    logic             mul_en_q;
    logic             accept;

    // HOLD accepts only when its result drains in the same cycle.
    assign o_mulctl_ready = !i_mulctl_flush &&
                            ((state_q == IDLE) || ((state_q == HOLD) && i_mulctl_out_ready));
    assign accept         = i_mulctl_valid && o_mulctl_ready;
    assign o_mulctl_busy  = (state_q == CALC) || ((state_q == HOLD) && !i_mulctl_out_ready);

    always_comb begin
        req_d         = '0;
        req_d.srcA    = MULCTL_XLEN'(i_mulctl_srcA);
        req_d.srcB    = MULCTL_XLEN'(i_mulctl_srcB);
        req_d.control = i_mulctl_control;
        req_d.isword  = i_mulctl_isword;
        req_d.rd      = MULCTL_TAG_W'(i_mulctl_rd);
    end

    always_ff @(posedge i_mulctl_clk) begin
        if (i_mulctl_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            mul_en_q <= 1'b0;
        end else if (i_mulctl_flush) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            mul_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q    <= req_d;
                        cnt_q    <= CNT_LOAD;
                        mul_en_q <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        result_q <= i_mulctl_mul_result;
                        valid_q  <= 1'b1;
                        mul_en_q <= 1'b0;
                        state_q  <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (i_mulctl_out_ready) begin
                        valid_q <= 1'b0;
                        if (accept) begin
                            req_q    <= req_d;
                            cnt_q    <= CNT_LOAD;
                            mul_en_q <= 1'b1;
                            state_q  <= CALC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    valid_q  <= 1'b0;
                    mul_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_mulctl_mul_srcA    = req_q.srcA[XLEN-1:0];
    assign o_mulctl_mul_srcB    = req_q.srcB[XLEN-1:0];
    assign o_mulctl_mul_control = req_q.control;
    assign o_mulctl_mul_isword  = req_q.isword;
    assign o_mulctl_mul_en      = mul_en_q;
    assign o_mulctl_valid       = valid_q;
    assign o_mulctl_result      = result_q;
    assign o_mulctl_rd          = req_q.rd[TAG_W-1:0];

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Directed bench for the multiply sequencer; three instances (MUL_CYCLES 2, 1, 4)
// share stimulus, each fed by a behavioural multiplier stub.
module tb_riscv_core_mul_ctrl;

    localparam int MC [3] = '{2, 1, 4};

    logic        clk;
    logic        rst;
    logic        valid;
    logic        flush;
    logic        out_ready;
    logic        isword;
    logic [63:0] srcA;
    logic [63:0] srcB;
    logic [1:0]  ctrl;
    logic [4:0]  rd;

    logic        rdy  [3];
    logic        vld  [3];
    logic        men  [3];
    logic        busy [3];
    logic        miw  [3];
    logic [1:0]  mctl [3];
    logic [63:0] msa  [3];
    logic [63:0] msb  [3];
    logic [63:0] mres [3];
    logic [63:0] res  [3];
    logic [4:0]  rdo  [3];

    int checks = 0;
    int errors = 0;

    // Behavioural stand-in for the sibling multiplier: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
    function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] c, input logic w);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        if (w) begin
            p = {64'd0, a} * {64'd0, b};
            return {{32{p[31]}}, p[31:0]};
        end
        ea = (c == 2'd3) ? {64'd0, a} : {{64{a[63]}}, a};
        eb = (c <= 2'd1) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ea * eb;
        return (c == 2'd0) ? p[63:0] : p[127:64];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            riscv_core_mul_ctrl #(.XLEN(64), .MUL_CYCLES(MC[gi]), .TAG_W(5)) dut (
                .i_mulctl_clk        (clk),
                .i_mulctl_rst        (rst),
                .i_mulctl_valid      (valid),
                .o_mulctl_ready      (rdy[gi]),
                .i_mulctl_srcA       (srcA),
                .i_mulctl_srcB       (srcB),
                .i_mulctl_control    (ctrl),
                .i_mulctl_isword     (isword),
                .i_mulctl_rd         (rd),
                .i_mulctl_flush      (flush),
                .o_mulctl_mul_srcA   (msa[gi]),
                .o_mulctl_mul_srcB   (msb[gi]),
                .o_mulctl_mul_control(mctl[gi]),
                .o_mulctl_mul_isword (miw[gi]),
                .o_mulctl_mul_en     (men[gi]),
                .i_mulctl_mul_result (mres[gi]),
                .o_mulctl_valid      (vld[gi]),
                .i_mulctl_out_ready  (out_ready),
                .o_mulctl_result     (res[gi]),
                .o_mulctl_rd         (rdo[gi]),
                .o_mulctl_busy       (busy[gi])
            );
            assign mres[gi] = mul_model(msa[gi], msb[gi], mctl[gi], miw[gi]);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                       input logic w, input logic [4:0] r);
        valid = 1'b1; srcA = a; srcB = b; ctrl = c; isword = w; rd = r;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc; cyc;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy[0]); end
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld[0]); end
        checks++; if (men[0] !== 1'b0) begin errors++; $display("FAIL reset_mul_en: got %b expected 0", men[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
        checks++; if (res[0] !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", res[0]); end
        checks++; if (rdo[0] !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rdo[0]); end
        checks++; if (msa[0] !== 64'd0 || miw[0] !== 1'b0) begin errors++; $display("FAIL reset_operands: got %h/%b expected 0/0", msa[0], miw[0]); end
        rst = 1'b0;
        $display("reset: ready=%b valid=%b", rdy[0], vld[0]);
    endtask

    task automatic test_latency_sweep;
        rst = 1'b1; cyc; rst = 1'b0;
        out_ready = 1'b1;
        req(64'd6, 64'd7, 2'd0, 1'b0, 5'd5);
        cyc;
        valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc;
            checks++; if (vld[0] !== (k == 2)) begin errors++; $display("FAIL sweep2_valid_k%0d: got %b expected %b", k, vld[0], (k == 2)); end
            checks++; if (vld[1] !== (k == 1)) begin errors++; $display("FAIL sweep1_valid_k%0d: got %b expected %b", k, vld[1], (k == 1)); end
            checks++; if (vld[2] !== (k == 4)) begin errors++; $display("FAIL sweep4_valid_k%0d: got %b expected %b", k, vld[2], (k == 4)); end
            checks++; if (men[2] !== (k < 4)) begin errors++; $display("FAIL sweep4_en_k%0d: got %b expected %b", k, men[2], (k < 4)); end
            if (k == 1) begin
                checks++; if (res[1] !== 64'd42) begin errors++; $display("FAIL sweep1_result: got %h expected 2a", res[1]); end
            end
            if (k == 4) begin
                checks++; if (res[2] !== 64'd42) begin errors++; $display("FAIL sweep4_result: got %h expected 2a", res[2]); end
            end
        end
        $display("sweep: 6*7 latencies 1/2/4 observed");
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        req(64'd3, 64'd5, 2'd0, 1'b0, 5'd7);
        #1;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b expected 1", rdy[0]); end
        cyc;
        valid = 1'b0;
        #1;
        checks++; if (men[0] !== 1'b1) begin errors++; $display("FAIL basic_en_c1: got %b expected 1", men[0]); end
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL basic_ready_calc: got %b expected 0", rdy[0]); end
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_calc: got %b expected 1", busy[0]); end
        checks++; if (msa[0] !== 64'd3 || msb[0] !== 64'd5) begin errors++; $display("FAIL basic_operands: got %h/%h expected 3/5", msa[0], msb[0]); end
        cyc;
        checks++; if (men[0] !== 1'b1 || vld[0] !== 1'b0) begin errors++; $display("FAIL basic_c2: got en=%b valid=%b expected en=1 valid=0", men[0], vld[0]); end
        cyc;
        checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", vld[0]); end
        checks++; if (res[0] !== 64'd15) begin errors++; $display("FAIL basic_result: got %h expected f", res[0]); end
        checks++; if (rdo[0] !== 5'd7) begin errors++; $display("FAIL basic_rd: got %0d expected 7", rdo[0]); end
        checks++; if (men[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL basic_hold_flags: got en=%b busy=%b expected 0/0", men[0], busy[0]); end
        cyc;
        checks++; if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin errors++; $display("FAIL basic_idle: got valid=%b ready=%b expected 0/1", vld[0], rdy[0]); end
        $display("basic: 3*5 -> %0d rd=%0d", res[0], rdo[0]);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        req(64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 2'd0, 1'b0, 5'd3);
        cyc;
        valid = 1'b0;
        cyc; cyc;
        for (int i = 0; i < 5; i++) begin
            req(64'd9, 64'd9, 2'd0, 1'b0, 5'd12);
            #1;
            checks++; if (vld[0] !== 1'b1 || res[0] !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b res=%h expected 1/fffffffffffffff8", i, vld[0], res[0]); end
            checks++; if (rdo[0] !== 5'd3 || busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_flags_%0d: got rd=%0d busy=%b ready=%b expected 3/1/0", i, rdo[0], busy[0], rdy[0]); end
            checks++; if (msa[0] !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL bp_operand_%0d: got %h expected fffffffffffffffe", i, msa[0]); end
            cyc;
        end
        valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (busy[0] !== 1'b0 || rdy[0] !== 1'b1 || vld[0] !== 1'b1) begin errors++; $display("FAIL bp_drain: got busy=%b ready=%b valid=%b expected 0/1/1", busy[0], rdy[0], vld[0]); end
        cyc;
        checks++; if (vld[0] !== 1'b0 || rdy[0] !== 1'b1 || men[0] !== 1'b0) begin errors++; $display("FAIL bp_idle: got valid=%b ready=%b en=%b expected 0/1/0", vld[0], rdy[0], men[0]); end
        $display("backpressure: -2*4 held 5 cycles then consumed");
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        req(64'd3, 64'd3, 2'd0, 1'b0, 5'd1);
        cyc;
        valid = 1'b0;
        cyc; cyc;
        req(64'h1_0000_0000, 64'h1_0000_0000, 2'd1, 1'b0, 5'd9);
        #1;
        checks++; if (rdy[0] !== 1'b1 || vld[0] !== 1'b1 || res[0] !== 64'd9) begin errors++; $display("FAIL b2b_hold: got ready=%b valid=%b res=%h expected 1/1/9", rdy[0], vld[0], res[0]); end
        cyc;
        valid = 1'b0;
        #1;
        checks++; if (men[0] !== 1'b1 || vld[0] !== 1'b0) begin errors++; $display("FAIL b2b_calc: got en=%b valid=%b expected 1/0", men[0], vld[0]); end
        checks++; if (msa[0] !== 64'h1_0000_0000 || mctl[0] !== 2'd1) begin errors++; $display("FAIL b2b_operands: got %h ctl=%0d expected 100000000 ctl=1", msa[0], mctl[0]); end
        cyc; cyc;
        checks++; if (vld[0] !== 1'b1 || res[0] !== 64'd1 || rdo[0] !== 5'd9) begin errors++; $display("FAIL b2b_result: got valid=%b res=%h rd=%0d expected 1/1/9", vld[0], res[0], rdo[0]); end
        cyc;
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %b expected 0", vld[0]); end
        $display("back_to_back: 9 then MULH 2^32*2^32 -> %h", 64'd1);
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        req(64'd2, 64'd2, 2'd0, 1'b0, 5'd4);
        cyc;
        valid = 1'b0;
        flush = 1'b1;
        #1;
        checks++; if (rdy[0] !== 1'b0 || men[0] !== 1'b1) begin errors++; $display("FAIL flush_calc_pre: got ready=%b en=%b expected 0/1", rdy[0], men[0]); end
        cyc;
        flush = 1'b0;
        #1;
        checks++; if (men[0] !== 1'b0 || vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin errors++; $display("FAIL flush_calc_post: got en=%b valid=%b ready=%b expected 0/0/1", men[0], vld[0], rdy[0]); end
        cyc; cyc;
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL flush_calc_novalid: got %b expected 0", vld[0]); end
        req(64'd2, 64'd2, 2'd0, 1'b0, 5'd4);
        cyc;
        valid = 1'b0;
        cyc; cyc;
        checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL flush_hold_pre: got %b expected 1", vld[0]); end
        req(64'd5, 64'd5, 2'd0, 1'b0, 5'd6);
        flush = 1'b1;
        #1;
        checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL flush_hold_ready: got %b expected 0", rdy[0]); end
        cyc;
        flush = 1'b0;
        valid = 1'b0;
        #1;
        checks++; if (vld[0] !== 1'b0 || men[0] !== 1'b0 || rdy[0] !== 1'b1) begin errors++; $display("FAIL flush_hold_post: got valid=%b en=%b ready=%b expected 0/0/1", vld[0], men[0], rdy[0]); end
        cyc;
        checks++; if (vld[0] !== 1'b0 || men[0] !== 1'b0) begin errors++; $display("FAIL flush_hold_norequest: got valid=%b en=%b expected 0/0", vld[0], men[0]); end
        $display("flush: CALC and HOLD flushed, flush-cycle request refused");
    endtask

    task automatic test_word;
        out_ready = 1'b1;
        req(64'h7FFF_FFFF, 64'd2, 2'd0, 1'b1, 5'd2);
        cyc;
        valid = 1'b0;
        isword = 1'b0;
        #1;
        checks++; if (miw[0] !== 1'b1) begin errors++; $display("FAIL word_isword: got %b expected 1", miw[0]); end
        cyc; cyc;
        checks++; if (vld[0] !== 1'b1 || res[0] !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL word_result: got valid=%b res=%h expected 1/fffffffffffffffe", vld[0], res[0]); end
        cyc;
        checks++; if (miw[0] !== 1'b1) begin errors++; $display("FAIL word_retain: got %b expected 1", miw[0]); end
        $display("word: 0x7fffffff*2 -> %h", res[0]);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        req(64'd6, 64'd6, 2'd0, 1'b0, 5'd8);
        cyc;
        valid = 1'b0;
        rst = 1'b1;
        cyc;
        checks++; if (vld[0] !== 1'b0 || men[0] !== 1'b0 || rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL rst_calc_flags: got valid=%b en=%b ready=%b busy=%b expected 0/0/1/0", vld[0], men[0], rdy[0], busy[0]); end
        checks++; if (msa[0] !== 64'd0 || rdo[0] !== 5'd0) begin errors++; $display("FAIL rst_calc_regs: got %h rd=%0d expected 0/0", msa[0], rdo[0]); end
        rst = 1'b0;
        cyc; cyc;
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL rst_calc_noresult: got %b expected 0", vld[0]); end
        out_ready = 1'b0;
        req(64'd6, 64'd6, 2'd0, 1'b0, 5'd8);
        cyc;
        valid = 1'b0;
        cyc; cyc;
        checks++; if (vld[0] !== 1'b1 || res[0] !== 64'd36) begin errors++; $display("FAIL rst_hold_pre: got valid=%b res=%h expected 1/24", vld[0], res[0]); end
        rst = 1'b1;
        cyc;
        checks++; if (vld[0] !== 1'b0 || res[0] !== 64'd0 || rdo[0] !== 5'd0) begin errors++; $display("FAIL rst_hold_regs: got valid=%b res=%h rd=%0d expected 0/0/0", vld[0], res[0], rdo[0]); end
        checks++; if (rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL rst_hold_flags: got ready=%b busy=%b expected 1/0", rdy[0], busy[0]); end
        rst = 1'b0;
        out_ready = 1'b1;
        $display("reset_mid: CALC and HOLD operations discarded");
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        isword = 1'b0; srcA = '0; srcB = '0; ctrl = '0; rd = '0;
        test_reset;
        test_latency_sweep;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_flush;
        test_word;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
